// File: rtl/display_dma_pattern_source.sv
// Display DMA read-channel pattern source: streams whole frames of a
// selectable test pattern as 64-bit two-pixel beats with valid/ready.
//
// Ports:
//   io_peripheralClk     sole clock
//   io_peripheralReset   asynchronous active-high reset
//   cfg_enable           run frames while high
//   cfg_mode             0 solid, 1 ramp, 2 colour bars, 3 checker
//   cfg_color            {R,G,B} for solid mode
//   display_dma_rdata    pixel x at [31:0], pixel x+1 at [63:32]
//   display_dma_rvalid   beat valid
//   display_dma_rkeep    byte enables
//   display_dma_rready   sink accepts beat
//   frame_start          pulse on the first STREAM cycle of a frame
//   frame_done           pulse on the cycle after the last accept
//   frame_count          completed frames, wrapping
//   busy                 high in STREAM or GAP
module display_dma_pattern_source #(
    parameter int FRAME_WIDTH  = 1920,
    parameter int FRAME_HEIGHT = 1080,
    parameter int FRAME_GAP    = 16,
    parameter int BAR_SHIFT    = 8
) (
    input  logic        io_peripheralClk,
    input  logic        io_peripheralReset,
    input  logic        cfg_enable,
    input  logic [1:0]  cfg_mode,
    input  logic [23:0] cfg_color,
    output logic [63:0] display_dma_rdata,
    output logic        display_dma_rvalid,
    output logic [7:0]  display_dma_rkeep,
    input  logic        display_dma_rready,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam logic [16:0] WIDTH17  = 17'(FRAME_WIDTH);
    localparam logic [15:0] LAST_Y   = 16'(FRAME_HEIGHT - 1);
    localparam logic [15:0] LAST_GAP = 16'(FRAME_GAP - 1);

    state_t      state, state_d;
    logic [15:0] x, x_d;
    logic [15:0] y, y_d;
    logic [15:0] gap_cnt, gap_d;
    logic [15:0] count_d;
    logic [1:0]  mode_q, mode_d;
    logic [23:0] color_q, color_d;
    logic [63:0] rdata_d;
    logic [7:0]  rkeep_d;
    logic        rvalid_d;
    logic        start_d;
    logic        done_d;
    logic        begin_frame;
    logic        last_x;
    logic        last_y;

    // Colour bars saturate at index 7 (black).
    function automatic logic [23:0] bar_rgb(input logic [15:0] px);
        logic [15:0] b;
        b = px >> BAR_SHIFT;
        bar_rgb = 24'h000000;
        if (b < 16'd7) begin
            case (b[2:0])
                3'd0:    bar_rgb = 24'hFFFFFF;
                3'd1:    bar_rgb = 24'hFFFF00;
                3'd2:    bar_rgb = 24'h00FFFF;
                3'd3:    bar_rgb = 24'h00FF00;
                3'd4:    bar_rgb = 24'hFF00FF;
                3'd5:    bar_rgb = 24'hFF0000;
                3'd6:    bar_rgb = 24'h0000FF;
                default: bar_rgb = 24'h000000;
            endcase
        end
    endfunction

    function automatic logic [31:0] pixel(
        input logic [1:0]  mode,
        input logic [23:0] color,
        input logic [15:0] px,
        input logic        row6,
        input logic        f0
    );
        logic [23:0] rgb;
        unique case (mode)
            2'd0:    rgb = color;
            2'd1:    rgb = {3{px[7:0]}};
            2'd2:    rgb = bar_rgb(px);
            default: rgb = (px[6] ^ row6 ^ f0) ? 24'hFFFFFF : 24'h000000;
        endcase
        return {8'h00, rgb};
    endfunction

    // Returns {rkeep, rdata}; the upper pixel is dropped past the line end.
    function automatic logic [71:0] beat(
        input logic [1:0]  mode,
        input logic [23:0] color,
        input logic [15:0] px,
        input logic        row6,
        input logic        f0
    );
        logic [15:0] nx;
        nx = px + 16'd1;
        if ({1'b0, nx} < WIDTH17)
            return {8'hFF, pixel(mode, color, nx, row6, f0),
                    pixel(mode, color, px, row6, f0)};
        else
            return {8'h0F, 32'h0, pixel(mode, color, px, row6, f0)};
    endfunction

    assign last_x = ({1'b0, x} + 17'd2) >= WIDTH17;
    assign last_y = (y == LAST_Y);
    assign busy   = (state != IDLE);

    always_comb begin
        state_d     = state;
        x_d         = x;
        y_d         = y;
        gap_d       = gap_cnt;
        count_d     = frame_count;
        mode_d      = mode_q;
        color_d     = color_q;
        rvalid_d    = display_dma_rvalid;
        rdata_d     = display_dma_rdata;
        rkeep_d     = display_dma_rkeep;
        start_d     = 1'b0;
        done_d      = 1'b0;
        begin_frame = 1'b0;

        unique case (state)
            IDLE: begin
                if (cfg_enable)
                    begin_frame = 1'b1;
            end
            STREAM: begin
                if (display_dma_rvalid && display_dma_rready) begin
                    if (last_x && last_y) begin
                        state_d  = GAP;
                        x_d      = 16'd0;
                        y_d      = 16'd0;
                        gap_d    = 16'd0;
                        rvalid_d = 1'b0;
                        rdata_d  = 64'h0;
                        rkeep_d  = 8'h00;
                        done_d   = 1'b1;
                        count_d  = frame_count + 16'd1;
                    end else begin
                        if (last_x) begin
                            x_d = 16'd0;
                            y_d = y + 16'd1;
                        end else begin
                            x_d = x + 16'd2;
                        end
                        {rkeep_d, rdata_d} = beat(mode_q, color_q, x_d,
                                                  y_d[6], frame_count[0]);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    if (cfg_enable)
                        begin_frame = 1'b1;
                    else
                        state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame entry: latch config and present beat 0 with rvalid.
        if (begin_frame) begin
            state_d  = STREAM;
            x_d      = 16'd0;
            y_d      = 16'd0;
            mode_d   = cfg_mode;
            color_d  = cfg_color;
            rvalid_d = 1'b1;
            start_d  = 1'b1;
            {rkeep_d, rdata_d} = beat(cfg_mode, cfg_color, 16'd0,
                                      1'b0, frame_count[0]);
        end
    end

    always_ff @(posedge io_peripheralClk or posedge io_peripheralReset) begin
        if (io_peripheralReset) begin
            state              <= IDLE;
            x                  <= 16'd0;
            y                  <= 16'd0;
            gap_cnt            <= 16'd0;
            frame_count        <= 16'd0;
            mode_q             <= 2'd0;
            color_q            <= 24'h0;
            display_dma_rvalid <= 1'b0;
            display_dma_rdata  <= 64'h0;
            display_dma_rkeep  <= 8'h00;
            frame_start        <= 1'b0;
            frame_done         <= 1'b0;
        end else begin
            state              <= state_d;
            x                  <= x_d;
            y                  <= y_d;
            gap_cnt            <= gap_d;
            frame_count        <= count_d;
            mode_q             <= mode_d;
            color_q            <= color_d;
            display_dma_rvalid <= rvalid_d;
            display_dma_rdata  <= rdata_d;
            display_dma_rkeep  <= rkeep_d;
            frame_start        <= start_d;
            frame_done         <= done_d;
        end
    end

endmodule

// File: tb/tb_display_dma_pattern_source.sv
// Self-checking bench for display_dma_pattern_source with a frame-level
// reference model, random backpressure and random pattern selection.
module tb_display_dma_pattern_source;

    localparam int W   = 5;
    localparam int H   = 3;
    localparam int G   = 2;
    localparam int BS  = 1;
    localparam int BPL = (W + 1) / 2;
    localparam int TOT = BPL * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_enable = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [23:0] cfg_color = 24'h0;
    logic [63:0] rdata;
    logic        rvalid;
    logic [7:0]  rkeep;
    logic        rready = 1'b1;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        busy;

    int checks = 0;
    int failures = 0;
    bit bp_on = 1'b0;

    display_dma_pattern_source #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .FRAME_GAP   (G),
        .BAR_SHIFT   (BS)
    ) dut (
        .io_peripheralClk  (clk),
        .io_peripheralReset(rst),
        .cfg_enable        (cfg_enable),
        .cfg_mode          (cfg_mode),
        .cfg_color         (cfg_color),
        .display_dma_rdata (rdata),
        .display_dma_rvalid(rvalid),
        .display_dma_rkeep (rkeep),
        .display_dma_rready(rready),
        .frame_start       (frame_start),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [23:0] BARS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic logic [31:0] mpix(input int mode, input logic [23:0] col,
                                         input int x, input int y, input int f0);
        int bi;
        logic [7:0] v;
        case (mode)
            0: return {8'h00, col};
            1: begin
                v = 8'(x % 256);
                return {8'h00, v, v, v};
            end
            2: begin
                bi = x >> BS;
                if (bi > 7) bi = 7;
                return {8'h00, BARS[bi]};
            end
            default: begin
                if ((((x / 64) % 2) ^ ((y / 64) % 2) ^ f0) != 0)
                    return 32'h00FFFFFF;
                return 32'h0;
            end
        endcase
    endfunction

    function automatic logic [71:0] exp_beat(input int b, input int mode,
                                             input logic [23:0] col, input int f0);
        int x, y;
        logic [31:0] lo;
        x = 2 * (b % BPL);
        y = b / BPL;
        lo = mpix(mode, col, x, y, f0);
        if (x + 1 < W)
            return {8'hFF, mpix(mode, col, x + 1, y, f0), lo};
        return {8'h0F, 32'h0, lo};
    endfunction

    int          m_phase;  // 0 idle, 1 streaming, 2 gap
    int          m_beat, m_gap, m_mode, m_f0;
    logic [23:0] m_col;
    logic [15:0] m_count;
    bit          m_start, m_done, m_rdy;

    always @(posedge clk or posedge rst) begin
        bit entering;
        if (rst) begin
            m_phase = 0; m_beat = 0; m_gap = 0; m_count = 16'd0;
            m_start = 0; m_done = 0; m_rdy = 0;
            m_mode = 0; m_col = 24'h0; m_f0 = 0;
        end else begin
            entering = 0;
            m_rdy = rready;
            m_start = 0;
            m_done = 0;
            case (m_phase)
                0: if (cfg_enable) entering = 1;
                1: if (rready) begin
                    m_beat++;
                    if (m_beat == TOT) begin
                        m_phase = 2;
                        m_gap = 1;
                        m_done = 1;
                        m_count = m_count + 16'd1;
                    end
                end
                default: begin
                    if (m_gap == G) begin
                        if (cfg_enable) entering = 1;
                        else m_phase = 0;
                    end else begin
                        m_gap++;
                    end
                end
            endcase
            if (entering) begin
                m_phase = 1;
                m_beat = 0;
                m_mode = int'(cfg_mode);
                m_col = cfg_color;
                m_f0 = int'(m_count[0]);
                m_start = 1;
            end
        end
    end

    // ---------------- compare process ----------------
    logic [63:0] acc_q[$];
    logic [7:0]  keep_q[$];
    int          fs_cnt = 0;
    bit          prev_v = 0;
    logic [63:0] prev_d;
    logic [7:0]  prev_k;

    always @(negedge clk) begin
        logic [71:0] e;
        if (rst) begin
            prev_v = 0;
        end else begin
            chk("rvalid", 64'(rvalid), 64'(m_phase == 1));
            chk("frame_start", 64'(frame_start), 64'(m_start));
            chk("frame_done", 64'(frame_done), 64'(m_done));
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("frame_count", 64'(frame_count), 64'(m_count));
            if (m_phase == 1) begin
                e = exp_beat(m_beat, m_mode, m_col, m_f0);
                chk("rdata", rdata, e[63:0]);
                chk("rkeep", 64'(rkeep), 64'(e[71:64]));
            end
            if (prev_v && !m_rdy) begin
                chk("hold_valid", 64'(rvalid), 64'd1);
                chk("hold_data", rdata, prev_d);
                chk("hold_keep", 64'(rkeep), 64'(prev_k));
            end
            if (frame_start) fs_cnt++;
            if (rvalid && rready) begin
                acc_q.push_back(rdata);
                keep_q.push_back(rkeep);
            end
            prev_v = rvalid;
            prev_d = rdata;
            prev_k = rkeep;
        end
    end

    always @(posedge clk) begin
        #1;
        rready = bp_on ? 1'($urandom % 2) : 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (acc_q.size() >= n) return;
        end
        chk("timeout_accepts", 64'(acc_q.size()), 64'(n));
    endtask

    task automatic wait_fs(input int n);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fs_cnt >= n) return;
        end
        chk("timeout_frame_start", 64'(fs_cnt), 64'(n));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy && !rvalid) return;
        end
        chk("timeout_idle", 64'(busy), 64'd0);
    endtask

    task automatic clear_log();
        acc_q.delete();
        keep_q.delete();
        fs_cnt = 0;
    endtask

    logic [63:0] ref_q[$];

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        chk("reset_rkeep", 64'(rkeep), 64'd0);
        chk("reset_count", 64'(frame_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step();

        // Solid, one frame, ready always high.
        clear_log();
        cfg_mode = 2'd0;
        cfg_color = 24'h123456;
        cfg_enable = 1'b1;
        wait_fs(1);
        step();
        cfg_enable = 1'b0;
        wait_idle();
        chk("solid_beats", 64'(acc_q.size()), 64'd9);
        if (acc_q.size() >= 9) begin
            chk("solid_b0", acc_q[0], 64'h00123456_00123456);
            chk("solid_k0", 64'(keep_q[0]), 64'hFF);
            chk("solid_b2", acc_q[2], 64'h00000000_00123456);
            chk("solid_k2", 64'(keep_q[2]), 64'h0F);
            chk("solid_b8", acc_q[8], 64'h00000000_00123456);
        end
        chk("solid_count", 64'(frame_count), 64'd1);

        // Ramp, enable dropped after beat 3; frame must still complete.
        clear_log();
        cfg_mode = 2'd1;
        cfg_enable = 1'b1;
        wait_acc(3);
        step();
        cfg_enable = 1'b0;
        wait_idle();
        repeat (4) step();
        chk("drop_rvalid", 64'(rvalid), 64'd0);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_count", 64'(frame_count), 64'd2);
        chk("ramp_beats", 64'(acc_q.size()), 64'd9);
        if (acc_q.size() >= 9) begin
            chk("ramp_b0", acc_q[0], 64'h00010101_00000000);
            chk("ramp_b1", acc_q[1], 64'h00030303_00020202);
            chk("ramp_b5", acc_q[5], 64'h00000000_00040404);
            chk("ramp_k5", 64'(keep_q[5]), 64'h0F);
        end
        ref_q = acc_q;

        // Same ramp frame with random backpressure.
        clear_log();
        bp_on = 1'b1;
        cfg_enable = 1'b1;
        wait_fs(1);
        step();
        cfg_enable = 1'b0;
        wait_idle();
        bp_on = 1'b0;
        chk("bp_beats", 64'(acc_q.size()), 64'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < acc_q.size(); i++)
            chk("bp_seq", acc_q[i], ref_q[i]);

        // Mode change mid-frame applies at the next frame.
        clear_log();
        cfg_mode = 2'd0;
        cfg_color = 24'hABCDEF;
        cfg_enable = 1'b1;
        wait_acc(5);
        step();
        cfg_mode = 2'd1;
        wait_fs(2);
        step();
        cfg_enable = 1'b0;
        wait_idle();
        chk("mc_beats", 64'(acc_q.size()), 64'd18);
        if (acc_q.size() >= 10) begin
            chk("mc_b4", acc_q[4], 64'h00ABCDEF_00ABCDEF);
            chk("mc_b8", acc_q[8], 64'h00000000_00ABCDEF);
            chk("mc_b9", acc_q[9], 64'h00010101_00000000);
        end

        // Random modes/colours, continuous frames, random backpressure.
        clear_log();
        bp_on = 1'b1;
        cfg_mode = 2'($urandom);
        cfg_color = 24'($urandom);
        cfg_enable = 1'b1;
        for (int f = 1; f <= 8; f++) begin
            wait_fs(f);
            step();
            cfg_mode = 2'($urandom);
            cfg_color = 24'($urandom);
        end
        cfg_enable = 1'b0;
        wait_idle();
        bp_on = 1'b0;
        chk("rand_beats", 64'(acc_q.size()), 64'(8 * TOT));

        // Asynchronous reset while streaming.
        clear_log();
        cfg_mode = 2'd1;
        cfg_enable = 1'b1;
        wait_acc(4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_rvalid", 64'(rvalid), 64'd0);
        chk("arst_rdata", rdata, 64'd0);
        chk("arst_rkeep", 64'(rkeep), 64'd0);
        chk("arst_count", 64'(frame_count), 64'd0);
        repeat (2) step();
        clear_log();
        rst = 1'b0;
        wait_fs(1);
        chk("post_rst_count", 64'(frame_count), 64'd0);
        wait_acc(1);
        if (acc_q.size() >= 1)
            chk("post_rst_b0", acc_q[0], 64'h00010101_00000000);
        step();
        cfg_enable = 1'b0;
        wait_idle();
        chk("post_rst_done", 64'(frame_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
